sum_product_pipe_acc: RTL and testbench
=======================================

// Module: sum_product_pipe_acc
// PURPOSE
//  Parametrised successor of the fixed 3-bit (a+b)*(c+d) pipeline. Computes p=(a+b)*(c+d)
//  per beat through a 3-register elastic pipeline with valid/ready on both sides.
//  Optional burst accumulation with saturation: mode 1 emits one sum-of-products per burst.
//  Sits between operand producers and result consumers in the arithmetic datapath.
// PARAMETERS
//  IN_W   3   operand width (a,b,c,d unsigned); sum width SW=IN_W+1, product width PW=2*SW
//  ACC_W  16  width of y and the accumulator; must be >= PW (elaboration error otherwise)
// PORTS
//  clock     in   1      single clock, all state updates on rising edge
//  reset     in   1      synchronous, active-low; sampled on rising edge of clock
//  in_valid  in   1      input beat valid
//  in_ready  out  1      block can accept a beat this cycle
//  a,b,c,d   in   IN_W   unsigned operands
//  acc_mode  in   1      0: one output per beat; 1: beat belongs to an accumulation burst
//  in_last   in   1      acc_mode=1 only: final beat of burst (ignored when acc_mode=0)
//  out_valid out  1      y/y_ovf valid
//  out_ready in   1      consumer accepts y this cycle
//  y         out  ACC_W  result, unsigned
//  y_ovf     out  1      burst saturated (always 0 for acc_mode=0 results)
// BEHAVIOUR
//  Reset (reset=0 at edge): all stage valids=0, out_valid=0, y=0, y_ovf=0, acc=0, ovf_sticky=0.
//   in_ready=0 while reset is low; in_ready=1 in first cycle after reset released.
//  Stages: S1 regs {sum0=a+b, sum1=c+d (SW bits, no loss), mode, last, v1};
//   S2 regs {p=sum0*sum1 (PW bits, exact), mode, last, v2}; S3 = output regs {y, y_ovf, out_valid}.
//  Handshake: transfer on in_valid&in_ready / out_valid&out_ready. adv3 = !out_valid | out_ready;
//   adv2 = !v2 | adv3; adv1 = !v1 | adv2; in_ready = adv1 (combinational, no comb path in->out).
//  Stage never advances when its source is empty; data held stable while stalled; no drop/dup.
//  Latency: beat accepted at edge E -> y visible with out_valid=1 after edge E+2 if never stalled.
//   Full throughput: 1 beat/cycle when out_ready=1.
//  S3 consume of S2 beat (v2 & adv3):
//   mode 0: y<=zero-ext(p), y_ovf<=0, out_valid<=1; acc/ovf_sticky unchanged.
//   mode 1, last=0: t=acc+p; acc<=sat(t), ovf_sticky|=(t>2^ACC_W-1); no output, out_valid<=0
//    if it was being popped.
//   mode 1, last=1: y<=sat(acc+p), y_ovf<=ovf_sticky|overflow of this add, out_valid<=1;
//    acc<=0, ovf_sticky<=0.
//   sat(t)=min(t, 2^ACC_W-1); sum computed at ACC_W+1 bits.
//  out_valid drops after pop if no new result enters S3 that edge.
//  Mode-0 beats inside an open burst pass through and do not disturb acc.
//  Burst with no last beat: acc persists indefinitely, only reset clears it.
//  Reset mid-operation: all in-flight beats and partial acc discarded; no stale output after.
// TESTING
//  T1 mode0 single: a=3,b=4,c=2,d=5 -> y=49, y_ovf=0, out_valid exactly 3rd cycle after accept.
//  T2 mode0 stream: 8 back-to-back beats, out_ready=1 -> 8 outputs in order, 1/cycle,
//     in_ready stays 1.
//  T3 backpressure: out_ready=0 for 6 cycles, in_valid=1 -> in_ready=0 after 3 accepts;
//     release -> all beats out in order, none lost/duplicated.
//  T4 mode1: (1,1,1,1),(2,2,2,2),(7,7,7,7,last) -> one output y=216, y_ovf=0;
//     next burst starts from 0.
//  T5 ACC_W=10: six mode1 beats (7,7,7,7), last on 6th -> y=1023, y_ovf=1;
//     next burst (1,1,1,1,last) -> y=4, y_ovf=0.
//  T6 reset low 1 cycle with 2 beats in flight + open burst -> out_valid=0 next cycle,
//     no output appears; new burst (1,1,1,1,last) -> y=4.

Source files
------------

// File: rtl/sum_product_pipe_acc_if.sv
// sum_product_pipe_acc_if: valid/ready bus; slave = pipeline side (operands in, y/y_ovf out), master = producer/consumer side
interface sum_product_pipe_acc_if #(
  parameter int IN_W = 3,
  parameter int ACC_W = 16
);
  logic in_valid, in_ready, acc_mode, in_last;
  logic out_valid, out_ready, y_ovf;
  logic [IN_W-1:0] a, b, c, d;
  logic [ACC_W-1:0] y;
  modport master (
    output in_valid, a, b, c, d, acc_mode, in_last, out_ready,
    input in_ready, out_valid, y, y_ovf
  );
  modport slave (
    input in_valid, a, b, c, d, acc_mode, in_last, out_ready,
    output in_ready, out_valid, y, y_ovf
  );
endinterface

// File: rtl/sum_product_pipe_acc.sv
// sum_product_pipe_acc: 3-stage elastic (a+b)*(c+d) pipeline with saturating burst accumulation; ports clock, reset (sync active-low), bus (slave)
module sum_product_pipe_acc #(
  parameter int IN_W = 3,
  parameter int ACC_W = 16
) (
  input logic clock,
  input logic reset,
  sum_product_pipe_acc_if.slave bus
);
  localparam int SW = IN_W + 1;
  localparam int PW = 2 * SW;
  localparam int TW = ACC_W + 1;
  localparam logic [ACC_W-1:0] MAX = '1;
  if (ACC_W < PW) begin : g_bad_acc_w
    $error("ACC_W must be >= 2*(IN_W+1)");
  end
  logic v1, v2, m1, m2, l1, l2, ov, yo, sticky;
  logic adv1, adv2, adv3;
  logic [SW-1:0] s0, s1;
  logic [PW-1:0] p;
  logic [ACC_W-1:0] acc, yr, sat;
  logic [ACC_W:0] t;
  always_comb begin
    adv3 = !ov || bus.out_ready;
    adv2 = !v2 || adv3;
    adv1 = !v1 || adv2;
    t = {1'b0, acc} + TW'(p);
    sat = t[ACC_W] ? MAX : t[ACC_W-1:0];
  end
  assign bus.in_ready = reset && adv1;
  assign bus.out_valid = ov;
  assign bus.y = yr;
  assign bus.y_ovf = yo;
  always_ff @(posedge clock) begin
    if (!reset) begin
      {v1, v2, m1, m2, l1, l2, ov, yo, sticky} <= '0;
      s0 <= '0;
      s1 <= '0;
      p <= '0;
      acc <= '0;
      yr <= '0;
    end else begin
      if (adv1) begin
        v1 <= bus.in_valid;
        s0 <= SW'(bus.a) + SW'(bus.b);
        s1 <= SW'(bus.c) + SW'(bus.d);
        m1 <= bus.acc_mode;
        l1 <= bus.in_last;
      end
      if (adv2) begin
        v2 <= v1;
        p <= PW'(s0) * PW'(s1);
        m2 <= m1;
        l2 <= l1;
      end
      if (adv3) begin
        ov <= v2 && (!m2 || l2);
        if (v2 && !m2) begin
          yr <= ACC_W'(p);
          yo <= 1'b0;
        end else if (v2 && l2) begin
          yr <= sat;
          yo <= sticky || t[ACC_W];
          acc <= '0;
          sticky <= 1'b0;
        end else if (v2) begin
          acc <= sat;
          sticky <= sticky || t[ACC_W];
        end
      end
    end
  end
endmodule

// File: tb/tb_sum_product_pipe_acc.sv
// tb_sum_product_pipe_acc: randomized scoreboard bench for sum_product_pipe_acc
module tb_sum_product_pipe_acc;
  localparam int IN_W = 3;
  localparam int ACC_W = 10;
  localparam longint MAXV = (longint'(1) << ACC_W) - 1;
  typedef struct {
    longint y;
    bit ovf;
    int acc_cyc;
    bit chk;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_lat = 1'b0;
  bit rnd_bp = 1'b0;
  longint burst = 0;
  exp_t exp_q[$];
  sum_product_pipe_acc_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();
  sum_product_pipe_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cyc++;
  end
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      exp_q.delete();
      burst = 0;
    end else if (bus.in_valid && bus.in_ready) begin
      longint pr;
      pr = longint'((int'(bus.a) + int'(bus.b)) * (int'(bus.c) + int'(bus.d)));
      if (!bus.acc_mode) exp_q.push_back('{pr, 1'b0, cyc, chk_lat});
      else begin
        burst += pr;
        if (bus.in_last) begin
          exp_q.push_back('{(burst > MAXV) ? MAXV : burst, burst > MAXV, cyc, chk_lat});
          burst = 0;
        end
      end
    end
  end
  initial forever begin
    @(negedge clock);
    if (reset && bus.out_valid && bus.out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got y=%0d ovf=%0b, required no output", bus.y, bus.y_ovf);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (longint'(bus.y) != e.y || bus.y_ovf != e.ovf) begin
          bad++;
          $display("FAIL result: got y=%0d ovf=%0b, required y=%0d ovf=%0b", bus.y, bus.y_ovf, e.y, e.ovf);
        end
        if (e.chk) begin
          total++;
          if (cyc - e.acc_cyc != 3) begin
            bad++;
            $display("FAIL latency: got %0d cycles, required 3", cyc - e.acc_cyc);
          end
        end
      end
    end
  end
  task automatic check(input string name, input longint got, input longint req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
    if (rnd_bp) bus.out_ready = $urandom_range(0, 3) != 0;
  endtask
  task automatic send(input int a_, input int b_, input int c_, input int d_, input bit m, input bit l, input bit chk, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    bus.a = IN_W'(a_);
    bus.b = IN_W'(b_);
    bus.c = IN_W'(c_);
    bus.d = IN_W'(d_);
    bus.acc_mode = m;
    bus.in_last = l;
    chk_lat = chk;
    bus.in_valid = 1'b1;
    while (!done) begin
      @(negedge clock);
      done = bus.in_ready;
      step();
      if (!done && ++waits > 300) begin
        check("accept_timeout", waits, 0);
        done = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    rnd_bp = 1'b0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
      step();
      n++;
    end
    repeat (2) step();
    check("drain_pending", exp_q.size(), 0);
  endtask
  initial begin
    int w, k, acc_n;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c = '0;
    bus.d = '0;
    bus.acc_mode = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) step();
    @(negedge clock);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_y", bus.y, 0);
    check("reset_y_ovf", bus.y_ovf, 0);
    check("reset_in_ready", bus.in_ready, 0);
    step();
    reset = 1'b1;
    @(negedge clock);
    check("ready_after_reset", bus.in_ready, 1);
    step();
    send(3, 4, 2, 5, 0, 0, 1, w);
    drain();
    for (int i = 0; i < 8; i++) begin
      send($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0, 0, 1, w);
      check("stream_in_ready_waits", w, 0);
    end
    drain();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.acc_mode = 1'b0;
    chk_lat = 1'b0;
    k = 0;
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      bus.a = IN_W'(k);
      bus.b = IN_W'(k + 1);
      bus.c = IN_W'(k + 2);
      bus.d = IN_W'(k + 3);
      @(negedge clock);
      if (bus.in_ready) begin
        acc_n++;
        k++;
      end
      step();
    end
    @(negedge clock);
    check("bp_accepts", acc_n, 3);
    check("bp_in_ready", bus.in_ready, 0);
    step();
    bus.in_valid = 1'b0;
    drain();
    send(1, 1, 1, 1, 1, 0, 0, w);
    send(2, 2, 2, 2, 1, 0, 0, w);
    send(7, 7, 7, 7, 1, 1, 1, w);
    drain();
    send(1, 1, 1, 1, 1, 1, 0, w);
    drain();
    for (int i = 0; i < 6; i++) send(7, 7, 7, 7, 1, i == 5, 0, w);
    drain();
    send(1, 1, 1, 1, 1, 1, 0, w);
    drain();
    bus.out_ready = 1'b0;
    send(7, 7, 7, 7, 1, 0, 0, w);
    send(7, 7, 7, 7, 1, 0, 0, w);
    send(2, 3, 4, 5, 0, 0, 0, w);
    send(1, 2, 3, 4, 0, 0, 0, w);
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_out_valid", bus.out_valid, 0);
    step();
    bus.out_ready = 1'b1;
    repeat (5) step();
    send(1, 1, 1, 1, 1, 1, 0, w);
    drain();
    rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 0, w);
      if ($urandom_range(0, 3) == 0) step();
    end
    send(7, 7, 7, 7, 1, 1, 0, w);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
